// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA result serializer.
package rsa_pkg;

    // Default width of a modular-exponentiation result word.
    localparam int RSA_BUS_WIDTH = 256;

    // Width of one serialized output byte.
    localparam int RSA_BYTE_W = 8;

    // Serializer state: waiting for a result, or streaming one out.
    typedef enum logic [0:0] {
        RSA_IDLE = 1'b0,
        RSA_SEND = 1'b1
    } rsa_state_e;

endpackage : rsa_pkg

// File: rtl/rsa_result_serializer.sv
// Serializes a wide modular-exponentiation result into a byte stream,
// most significant byte first, with a valid/ready handshake. A new result
// is captured on the rising edge of the level-type in_valid. A result that
// arrives while a word is still in flight is dropped and flagged by the
// sticky overrun output, except when it lines up with the final-byte
// handshake, in which case it is streamed back-to-back.
module rsa_result_serializer
    import rsa_pkg::*;
#(
    parameter int BUS_WIDTH     = RSA_BUS_WIDTH,
    parameter int COUNTER_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic [RSA_BYTE_W-1:0] byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  byte_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int NUM_BYTES = BUS_WIDTH / RSA_BYTE_W;
    localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(NUM_BYTES - 1);

    rsa_state_e             state_q,     state_d;
    logic                   valid_dly_q, valid_dly_d;
    logic [BUS_WIDTH-1:0]   shreg_q,     shreg_d;
    logic [COUNTER_WIDTH-1:0] idx_q,     idx_d;
    logic                   overrun_q,   overrun_d;

    logic capture_s;
    logic handshake_s;
    logic at_last_s;

    // Event decode: rising edge of in_valid, accepted byte, final byte index.
    always_comb begin
        capture_s   = in_valid & ~valid_dly_q;
        handshake_s = (state_q == RSA_SEND) & byte_ready;
        at_last_s   = (idx_q == LAST_IDX);
    end

    // State and datapath registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RSA_IDLE;
            valid_dly_q <= 1'b0;
            shreg_q     <= {BUS_WIDTH{1'b0}};
            idx_q       <= {COUNTER_WIDTH{1'b0}};
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_dly_q <= valid_dly_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic: leave SEND only after the final byte is accepted,
    // unless a new result arrives in that same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RSA_IDLE: begin
                if (capture_s) begin
                    state_d = RSA_SEND;
                end else begin
                    state_d = RSA_IDLE;
                end
            end
            RSA_SEND: begin
                if (handshake_s && at_last_s && !capture_s) begin
                    state_d = RSA_IDLE;
                end else begin
                    state_d = RSA_SEND;
                end
            end
            default: begin
                state_d = RSA_IDLE;
            end
        endcase
    end

    // Datapath: capture a word, shift one byte per handshake, flag drops.
    always_comb begin
        valid_dly_d = in_valid;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        overrun_d   = overrun_q;
        case (state_q)
            RSA_IDLE: begin
                if (capture_s) begin
                    shreg_d = in_data;
                    idx_d   = {COUNTER_WIDTH{1'b0}};
                end else begin
                    shreg_d = shreg_q;
                    idx_d   = idx_q;
                end
            end
            RSA_SEND: begin
                if (handshake_s && at_last_s) begin
                    // Final byte leaves; a coincident result reloads cleanly.
                    if (capture_s) begin
                        shreg_d = in_data;
                        idx_d   = {COUNTER_WIDTH{1'b0}};
                    end else begin
                        shreg_d = shreg_q;
                        idx_d   = idx_q;
                    end
                end else begin
                    if (handshake_s) begin
                        shreg_d = {shreg_q[BUS_WIDTH-RSA_BYTE_W-1:0], {RSA_BYTE_W{1'b0}}};
                        idx_d   = idx_q + COUNTER_WIDTH'(1);
                    end else begin
                        shreg_d = shreg_q;
                        idx_d   = idx_q;
                    end
                    // Any other result arriving mid-word is lost.
                    if (capture_s) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                end
            end
            default: begin
                shreg_d = {BUS_WIDTH{1'b0}};
                idx_d   = {COUNTER_WIDTH{1'b0}};
            end
        endcase
    end

    // Outputs decoded from registered state only; all zero outside SEND.
    always_comb begin
        byte_valid = 1'b0;
        busy       = 1'b0;
        byte_last  = 1'b0;
        byte_out   = {RSA_BYTE_W{1'b0}};
        overrun    = overrun_q;
        if (state_q == RSA_SEND) begin
            byte_valid = 1'b1;
            busy       = 1'b1;
            byte_last  = at_last_s;
            byte_out   = shreg_q[BUS_WIDTH-1 -: RSA_BYTE_W];
        end else begin
            byte_valid = 1'b0;
            busy       = 1'b0;
            byte_last  = 1'b0;
            byte_out   = {RSA_BYTE_W{1'b0}};
        end
    end

endmodule : rsa_result_serializer

// File: tb/tb_rsa_result_serializer.sv
// Self-checking bench for rsa_result_serializer (default 256-bit word).
// A queue-based reference model tracks the bytes still owed to the consumer.
module tb_rsa_result_serializer;

    logic         clk;
    logic         reset;
    logic [255:0] in_data;
    logic         in_valid;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_ready;
    logic         byte_last;
    logic         busy;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_prev;

    // observed stream
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         n_last;
    logic [7:0] last_byte;

    typedef struct {
        logic       v;
        logic       r;
        logic [7:0] e_byte;
        logic       e_valid;
        logic       e_last;
        logic       e_busy;
        logic       e_ovr;
    } vec_t;
    vec_t vecs[8];

    logic [255:0] w1;
    logic [255:0] wff;

    rsa_result_serializer #(.BUS_WIDTH(256), .COUNTER_WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .byte_last (byte_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
        return w;
    endfunction

    task automatic model_load(input logic [255:0] d);
        mq.delete();
        for (int i = 0; i < 32; i++) mq.push_back(d[255-8*i -: 8]);
    endtask

    task automatic set_exp(input logic [255:0] d);
        for (int i = 0; i < 32; i++) exp_q.push_back(d[255-8*i -: 8]);
    endtask

    // Compare the observed byte stream with exp_q.
    task automatic check_stream(input string name);
        int bad;
        bad = 0;
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        if (got_q.size() == exp_q.size()) begin
            for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        end else begin
            bad = 1;
        end
        check({name, "_bytes_bad"}, 64'(bad), 64'd0);
    endtask

    // One clock cycle: drive at negedge, model at posedge, compare after it.
    task automatic cycle(input logic v, input logic [255:0] d, input logic r);
        logic cap;
        logic hs;
        logic mv;
        logic [11:0] exp_v;
        in_valid   = v;
        in_data    = d;
        byte_ready = r;
        #1;
        if (byte_valid && r) begin
            got_q.push_back(byte_out);
            if (byte_last) begin
                n_last++;
                last_byte = byte_out;
            end
        end
        @(posedge clk);
        mv  = (mq.size() > 0);
        hs  = mv && r;
        cap = v && !m_prev;
        if (cap && (!mv || (hs && mq.size() == 1))) begin
            model_load(d);
        end else begin
            if (cap) m_ovr = 1'b1;
            if (hs) void'(mq.pop_front());
        end
        m_prev = v;
        #1;
        exp_v = {(mq.size() > 0), (mq.size() > 0), (mq.size() == 1), m_ovr,
                 (mq.size() > 0) ? mq[0] : 8'h00};
        check("model_cycle", 64'({busy, byte_valid, byte_last, overrun, byte_out}), 64'(exp_v));
        @(negedge clk);
    endtask

    // Run with a repeating ready pattern until busy drops or budget expires.
    task automatic drain(input logic [3:0] pat, input int budget, input string name, output int ncyc);
        int c;
        c = 0;
        while (busy && c < budget) begin
            cycle(1'b0, 256'd0, pat[c % 4]);
            c++;
        end
        ncyc = c;
        check({name, "_drained"}, 64'(busy), 64'd0);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic reset_dut();
        #2;
        reset = 1'b0;
        #1;
        check("reset_immediate", 64'({busy, byte_valid, byte_last, overrun, byte_out}), 64'd0);
        mq.delete();
        m_ovr  = 1'b0;
        m_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_held", 64'({busy, byte_valid, byte_last, overrun, byte_out}), 64'd0);
        reset = 1'b1;
        got_q.delete();
        exp_q.delete();
        n_last = 0;
    endtask

    initial begin
        int nc;
        logic [255:0] w2;
        logic v_r;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 256'd0;
        byte_ready = 1'b0;
        m_ovr      = 1'b0;
        m_prev     = 1'b0;
        n_last     = 0;
        last_byte  = 8'h00;
        for (int i = 0; i < 32; i++) w1[255-8*i -: 8] = 8'(i + 1);
        wff = {256{1'b1}};

        vecs[0] = '{v:1'b0, r:1'b1, e_byte:8'h00, e_valid:1'b0, e_last:1'b0, e_busy:1'b0, e_ovr:1'b0};
        vecs[1] = '{v:1'b1, r:1'b0, e_byte:8'h01, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b0};
        vecs[2] = '{v:1'b1, r:1'b0, e_byte:8'h01, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b0};
        vecs[3] = '{v:1'b1, r:1'b1, e_byte:8'h02, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b0};
        vecs[4] = '{v:1'b0, r:1'b0, e_byte:8'h02, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b0};
        vecs[5] = '{v:1'b0, r:1'b1, e_byte:8'h03, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b0};
        vecs[6] = '{v:1'b1, r:1'b1, e_byte:8'h04, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b1};
        vecs[7] = '{v:1'b1, r:1'b1, e_byte:8'h05, e_valid:1'b1, e_last:1'b0, e_busy:1'b1, e_ovr:1'b1};

        @(negedge clk);
        check("reset_state", 64'({busy, byte_valid, byte_last, overrun, byte_out}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table: latency, stall hold, level valid, mid-word overrun.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].v, w1, vecs[i].r);
            check($sformatf("vec%0d", i),
                  64'({byte_valid, byte_last, busy, overrun, byte_out}),
                  64'({vecs[i].e_valid, vecs[i].e_last, vecs[i].e_busy, vecs[i].e_ovr, vecs[i].e_byte}));
        end

        // Test 1: full word, ready always high.
        reset_dut();
        cycle(1'b1, w1, 1'b1);
        drain(4'b1111, 100, "t1", nc);
        check("t1_cycles", 64'(nc), 64'd32);
        set_exp(w1);
        check_stream("t1");
        check("t1_last_count", 64'(n_last), 64'd1);
        check("t1_last_byte", 64'(last_byte), 64'h20);

        // Test 2: ready pattern 1,0,0,1.
        reset_dut();
        cycle(1'b1, w1, 1'b1);
        drain(4'b1001, 300, "t2", nc);
        set_exp(w1);
        check_stream("t2");

        // Test 3: second result at byte index 10 is dropped.
        reset_dut();
        w2 = rand_word();
        cycle(1'b1, w1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 256'd0, 1'b1);
        cycle(1'b1, w2, 1'b1);
        drain(4'b1111, 100, "t3", nc);
        for (int i = 0; i < 40; i++) cycle(1'b0, 256'd0, 1'b1);
        set_exp(w1);
        check_stream("t3");
        check("t3_overrun", 64'(overrun), 64'd1);

        // Test 4: new result coincides with final-byte handshake.
        reset_dut();
        cycle(1'b1, w1, 1'b1);
        for (int i = 0; i < 31; i++) cycle(1'b0, 256'd0, 1'b1);
        check("t4_at_last", 64'({byte_last, byte_out}), 64'h120);
        cycle(1'b1, wff, 1'b1);
        check("t4_reload", 64'({busy, byte_last, byte_out}), 64'h2ff);
        drain(4'b1111, 100, "t4", nc);
        check("t4_cycles", 64'(nc), 64'd32);
        set_exp(w1);
        set_exp(wff);
        check_stream("t4");
        check("t4_overrun", 64'(overrun), 64'd0);

        // Test 5: reset at byte index 5 abandons the word.
        reset_dut();
        cycle(1'b1, w1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 256'd0, 1'b1);
        check("t5_index5", 64'(byte_out), 64'h06);
        in_valid = 1'b0;
        reset_dut();
        for (int i = 0; i < 40; i++) cycle(1'b0, 256'd0, 1'b1);
        check("t5_no_bytes", 64'(got_q.size()), 64'd0);

        // Test 6: in_valid high across reset release and 100 cycles.
        w2 = rand_word();
        in_valid = 1'b1;
        reset_dut();
        for (int i = 0; i < 100; i++) cycle(1'b1, w2, 1'b1);
        set_exp(w2);
        check_stream("t6");
        check("t6_overrun", 64'(overrun), 64'd0);

        // Randomized traffic against the reference model.
        in_valid = 1'b0;
        reset_dut();
        v_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 2) v_r = ~v_r;
            cycle(v_r, rand_word(), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rsa_result_serializer

// File: doc/rsa_result_serializer.md
RSA_RESULT_SERIALIZER -- requirements
Module: rsa_result_serializer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 256, meaning the result word width; it SHALL be a multiple of 8.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 5, meaning the byte-index width; it SHALL hold BUS_WIDTH/8-1.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  BUS_WIDTH  meaning the modular-exponentiation result word.
REQ-006 SHALL have port in_valid  input  1  meaning the level-type result-valid flag from the exponentiation unit.
REQ-007 SHALL have port byte_out  output  8  meaning the current output byte.
REQ-008 SHALL have port byte_valid  output  1  meaning byte_out holds a byte offered to the consumer.
REQ-009 SHALL have port byte_ready  input  1  meaning the consumer accepts byte_out this cycle.
REQ-010 SHALL have port byte_last  output  1  meaning the offered byte is the final byte of the word.
REQ-011 SHALL have port busy  output  1  meaning a word is captured and not yet fully sent.
REQ-012 SHALL have port overrun  output  1  meaning a sticky flag that a new result was dropped.

Function
REQ-013 SHALL register in_valid into valid_d each cycle; a capture event SHALL be in_valid=1 with valid_d=0 (rising edge).
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 IDLE: on a capture event, SHALL load in_data into a shift register, clear the byte index to 0, and enter SEND.
REQ-016 SEND: SHALL drive byte_valid=1 and busy=1, with byte_out equal to shift register bits [BUS_WIDTH-1:BUS_WIDTH-8].
REQ-017 Byte order SHALL be most significant byte first.
REQ-018 A handshake SHALL occur when byte_valid=1 and byte_ready=1 in the same cycle.
REQ-019 On a handshake with index < BUS_WIDTH/8-1, SHALL shift the register left by 8 and increment the index.
REQ-020 On a handshake with index = BUS_WIDTH/8-1, SHALL return to IDLE.
REQ-021 byte_last SHALL be 1 only in SEND with index = BUS_WIDTH/8-1.
REQ-022 While byte_valid=1 and byte_ready=0, byte_out and byte_last SHALL hold stable.
REQ-023 Latency: a capture event sampled at edge k SHALL give byte_valid=1 after edge k, presenting the MSB byte.
REQ-024 Throughput: with byte_ready held at 1, a full word SHALL take exactly BUS_WIDTH/8 cycles (32 at default).
REQ-025 A capture event in SEND coinciding with the final-byte handshake SHALL load the new word and remain in SEND with index 0, without setting overrun.
REQ-026 Any other capture event in SEND SHALL be dropped, set overrun=1, and leave the word in flight unaffected.
REQ-027 overrun SHALL remain 1 until reset.
REQ-028 In IDLE, byte_valid, byte_last and busy SHALL be 0, and byte_out SHALL be 0.
REQ-029 in_valid held high across many cycles SHALL produce exactly one capture.

Reset
REQ-030 Asserting reset low SHALL immediately force state=IDLE, valid_d=0, shift register=0, index=0 and overrun=0.
REQ-031 While reset is asserted, all outputs SHALL read 0.
REQ-032 Reset asserted mid-word SHALL abandon the word; no further bytes of it SHALL be emitted.
REQ-033 If in_valid=1 at reset release, the first clock edge SHALL count as a capture event (valid_d=0).

Structure
REQ-034 BUS_WIDTH default, byte width (8) and the IDLE/SEND state encoding SHALL live in shared package rsa_pkg.
REQ-035 The block SHALL be a single module with no sub-module.
REQ-036 It SHALL sit directly downstream of the modular-exponentiation unit, with in_data/in_valid tied to that unit's out/valid.

Verification
REQ-037 Test 1: in_data=0x0102...1F20 (bytes 01..20), in_valid rising, byte_ready=1 -> bytes 0x01..0x20 on 32 consecutive cycles; byte_last only with 0x20; busy falls after the final handshake.
REQ-038 Test 2: byte_ready toggling 1,0,0,1 per cycle -> each byte held stable while ready=0; sequence identical to Test 1; no byte lost or duplicated.
REQ-039 Test 3: second rising edge of in_valid at byte index 10 -> overrun=1; the original word completes unchanged; no second word is emitted.
REQ-040 Test 4: rising edge coincident with the final-byte handshake, new word 0xFF..FF -> 32 bytes 0xFF follow back-to-back; overrun=0.
REQ-041 Test 5: reset asserted low at byte index 5 -> outputs 0 immediately; after release with in_valid=0, no bytes are emitted.
REQ-042 Test 6: in_valid held 1 for 100 cycles -> exactly one 32-byte word is emitted.
